// File: rtl/if_stage_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake, and feeds IF/ID with NOP bubbles.
// Optional macro IF_HOLD_BUFFER_EN adds a HOLD state that buffers a word returned during a freeze.
module if_stage_fetch_unit #(
    parameter int unsigned            ADDRESS_LEN = 32,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0,
    parameter logic [ADDRESS_LEN-1:0] NOP_INSTR   = ADDRESS_LEN'(32'hE1A00000)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [ADDRESS_LEN-1:0] branch_address,
    output logic                   mem_req,
    output logic [ADDRESS_LEN-1:0] mem_addr,
    input  logic                   mem_ready,
    input  logic [ADDRESS_LEN-1:0] mem_rdata,
    output logic [ADDRESS_LEN-1:0] PC,
    output logic [ADDRESS_LEN-1:0] Instruction,
    output logic                   valid
);

    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ADDRESS_LEN-1:0] pc_reg;
    logic [ADDRESS_LEN-1:0] pc_next;
    logic [ADDRESS_LEN-1:0] target;
    logic [ADDRESS_LEN-1:0] target_next;
    logic [ADDRESS_LEN-1:0] pc_inc;
    logic [ADDRESS_LEN-1:0] br_addr;
`ifdef IF_HOLD_BUFFER_EN
    logic [ADDRESS_LEN-1:0] hold_buf;
    logic [ADDRESS_LEN-1:0] hold_buf_next;
`endif

    assign pc_inc  = pc_reg + ADDRESS_LEN'(PC_STEP);
    assign br_addr = {branch_address[ADDRESS_LEN-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_REQ;
            pc_reg <= RESET_PC;
            target <= RESET_PC;
        end else begin
            state  <= state_next;
            pc_reg <= pc_next;
            target <= target_next;
        end
    end

`ifdef IF_HOLD_BUFFER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_buf <= NOP_INSTR;
        end else begin
            hold_buf <= hold_buf_next;
        end
    end
`endif

    // Next-state and combinational outputs; a redirect always beats a freeze.
    always_comb begin
        state_next  = state;
        pc_next     = pc_reg;
        target_next = target;
`ifdef IF_HOLD_BUFFER_EN
        hold_buf_next = hold_buf;
`endif
        mem_req     = 1'b0;
        mem_addr    = pc_reg;
        valid       = 1'b0;
        Instruction = NOP_INSTR;
        PC          = pc_inc;

        case (state)
            ST_REQ: begin
                mem_req = 1'b1;
                if (branch_taken) begin
                    if (mem_ready) begin
                        pc_next = br_addr;
                    end else begin
                        target_next = br_addr;
                        state_next  = ST_DRAIN;
                    end
                end else if (mem_ready) begin
                    valid       = 1'b1;
                    Instruction = mem_rdata;
                    if (!freeze) begin
                        pc_next = pc_inc;
                    end
`ifdef IF_HOLD_BUFFER_EN
                    else begin
                        hold_buf_next = mem_rdata;
                        state_next    = ST_HOLD;
                    end
`endif
                end
            end
`ifdef IF_HOLD_BUFFER_EN
            ST_HOLD: begin
                if (branch_taken) begin
                    pc_next    = br_addr;
                    state_next = ST_REQ;
                end else begin
                    valid       = 1'b1;
                    Instruction = hold_buf;
                    if (!freeze) begin
                        pc_next    = pc_inc;
                        state_next = ST_REQ;
                    end
                end
            end
`endif
            // Old request must complete before the redirect target is fetched.
            ST_DRAIN: begin
                mem_req = 1'b1;
                if (branch_taken) begin
                    target_next = br_addr;
                    if (mem_ready) begin
                        pc_next    = br_addr;
                        state_next = ST_REQ;
                    end
                end else if (mem_ready) begin
                    pc_next    = target;
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_REQ;
            end
        endcase

        if (rst) begin
            mem_req     = 1'b0;
            valid       = 1'b0;
            Instruction = NOP_INSTR;
            PC          = '0;
        end
    end

endmodule

// File: tb/tb_if_stage_fetch_unit.sv
// Bench for if_stage_fetch_unit: random-latency memory, program-order scoreboard of captured instructions.
// Works with or without IF_HOLD_BUFFER_EN; only the request count in the freeze scenario differs.
module tb_if_stage_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'hE1A0_0000;
    localparam logic [31:0] MEM_OFS  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        valid;

    if_stage_fetch_unit #(
        .ADDRESS_LEN(32),
        .RESET_PC   (RESET_PC),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .branch_taken  (branch_taken),
        .branch_address(branch_address),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .PC            (PC),
        .Instruction   (Instruction),
        .valid         (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          errors   = 0;
    int          captures = 0;
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    logic        outstanding = 1'b0;
    logic [31:0] prev_addr   = '0;
    logic [31:0] exp_addr    = RESET_PC;
    logic [31:0] watch_addr  = '0;
    int          watch_hs    = 0;
    logic        cur_req;
    logic [31:0] cur_addr;
    int          c0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive controls, answer as memory, advance the program-order model.
    task automatic step(input logic r, input logic f, input logic b, input logic [31:0] ba);
        @(posedge clk);
        #1;
        rst = r; freeze = f; branch_taken = b; branch_address = ba;
        #1;
        if (outstanding && !r) begin
            check("req_held", 32'(mem_req), 32'd1);
            check("addr_stable", mem_addr, prev_addr);
        end
        if (mem_req) begin
            check("addr_align", {30'b0, mem_addr[1:0]}, 32'd0);
            if (!outstanding) wait_cnt = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
            if (wait_cnt == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mem_addr + MEM_OFS;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                wait_cnt--;
            end
        end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
        end
        if (mem_req && mem_ready && mem_addr == watch_addr) watch_hs++;
        cur_req     = mem_req;
        cur_addr    = mem_addr;
        outstanding = mem_req && !mem_ready;
        prev_addr   = mem_addr;
        // Reference: captured stream is sequential from reset or from the latest redirect.
        if (r) begin
            sb_q.delete();
            exp_addr = RESET_PC;
        end else if (b) begin
            sb_q.delete();
            exp_addr = {ba[31:2], 2'b00};
        end
        if (sb_q.size() == 0) begin
            sb_q.push_back('{pc: exp_addr + 32'd4, instr: exp_addr + MEM_OFS});
            exp_addr = exp_addr + 32'd4;
        end
    endtask

    // Monitor: IF/ID captures whenever valid is high and the pipe is not frozen.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_mem_req", 32'(mem_req), 32'd0);
            check("rst_valid", 32'(valid), 32'd0);
            check("rst_instr", Instruction, NOP);
            check("rst_pc", PC, 32'd0);
        end else begin
            if (branch_taken) check("branch_bubble", 32'(valid), 32'd0);
            if (!valid) check("bubble_nop", Instruction, NOP);
            if (valid && !freeze) begin
                exp_t e;
                captures++;
                if (sb_q.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("cap_pc", PC, e.pc);
                    check("cap_instr", Instruction, e.instr);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = '0;
        mem_ready = 1'b0; mem_rdata = '0;

        // Reset, then zero-wait streaming
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        c0 = captures;
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk); #1;
        check("zero_wait_count", 32'(captures - c0), 32'd3);

        // Two wait states: one instruction per three cycles
        step(1'b1, 1'b0, 1'b0, 32'h0);
        wait_cfg = 2;
        c0 = captures;
        repeat (9) step(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk); #1;
        check("wait2_count", 32'(captures - c0), 32'd3);

        // Freeze across the 0x10 fetch
        wait_cfg = 0;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
        watch_addr = 32'h10;
        watch_hs   = 0;
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("after_freeze_req", 32'(cur_req), 32'd1);
        check("after_freeze_addr", cur_addr, 32'h14);
`ifdef IF_HOLD_BUFFER_EN
        check("freeze_handshakes", 32'(watch_hs), 32'd1);
`else
        check("freeze_handshakes", 32'(watch_hs), 32'd4);
`endif

        // Redirect to 0x200 while the 0x40 request is stalled
        step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (16) step(1'b0, 1'b0, 1'b0, 32'h0);
        wait_cfg = 3;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("stall_addr", cur_addr, 32'h40);
        step(1'b0, 1'b0, 1'b1, 32'h200);
        wait_cfg = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            if (cur_addr != 32'h40) break;
        end
        check("drain_target_addr", cur_addr, 32'h200);
        check("drain_target_req", 32'(cur_req), 32'd1);
        c0 = captures;
        @(negedge clk); #1;
        check("drain_target_cap", 32'(captures - c0), 32'd1);

        // Branch and freeze together, unaligned target
        step(1'b0, 1'b1, 1'b1, 32'h303);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("branch_over_freeze", cur_addr, 32'h300);

        // Reset during an outstanding request
        wait_cfg = 5;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        wait_cfg = 0;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("restart_req", 32'(cur_req), 32'd1);
        check("restart_addr", cur_addr, RESET_PC);

        // PC wrap
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_fetch", cur_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_next", cur_addr, 32'h0);

        // Random traffic
        wait_cfg = -1;
        c0 = captures;
        for (int i = 0; i < 2000; i++) begin
            logic        r;
            logic        f;
            logic        b;
            logic [31:0] ba;
            r  = ($urandom_range(0, 99) == 0);
            f  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 9) == 0);
            ba = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                             : ($urandom & 32'h0000_0FFF);
            step(r, f, b, ba);
        end
        @(negedge clk); #1;
        check("random_progress", 32'(captures - c0 > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage_fetch_unit.md
# if_stage_fetch_unit

Instruction-fetch stage of the ARM pipeline: owns the program counter, issues instruction reads to the instruction memory over a req/ready handshake, and presents `PC` and `Instruction` to the IF/ID pipeline register. It sits directly upstream of that register. It absorbs memory wait states, hazard freezes and taken-branch redirects. It emits a NOP bubble whenever no valid instruction is available, so the IF/ID register never captures a duplicate or a stale fetch.

## Interface
- `ADDRESS_LEN`, default 32: width of PC, addresses and instruction words.
- `RESET_PC`, default 0: PC value loaded on reset.
- `NOP_INSTR`, default 32'hE1A00000 (MOV r0, r0): bubble encoding.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `freeze`  in  1  hazard stall from the hazard unit; the fetch must not advance.
- `branch_taken`  in  1  redirect request from EXE.
- `branch_address`  in  ADDRESS_LEN  redirect target.
- `mem_req`  out  1  instruction read request.
- `mem_addr`  out  ADDRESS_LEN  read address; word aligned.
- `mem_ready`  in  1  read data valid and request accepted this cycle.
- `mem_rdata`  in  ADDRESS_LEN  instruction word.
- `PC`  out  ADDRESS_LEN  address of the presented instruction + 4.
- `Instruction`  out  ADDRESS_LEN  fetched instruction, or `NOP_INSTR`.
- `valid`  out  1  `Instruction` is real.

## Operation
- Registers:
  - `pc_reg`: address of the next fetch.
  - `state`: REQ, HOLD or DRAIN.
  - `target`: pending redirect address.
  - `buf`: buffered instruction, HOLD state only.
- **Reset**, applied while `rst`=1 at a rising edge:
  - Loads `pc_reg`=`RESET_PC` and `state`=REQ.
  - While `rst`=1, all outputs are forced as follows: `mem_req`=0, `valid`=0, `Instruction`=`NOP_INSTR`, `PC`=0.
  - Reset mid-transaction abandons the outstanding request. Memory must tolerate dropped requests.
- **REQ**:
  - Drives `mem_req`=1 and `mem_addr`=`pc_reg`. Both are held stable until `mem_ready`.
  - On `mem_ready`, `!freeze`, `!branch_taken`:
    - Outputs: `valid`=1, `Instruction`=`mem_rdata`, `PC`=`pc_reg`+4. These are combinational in the same cycle.
    - Next: `pc_reg` <= `pc_reg`+4; stay in REQ.
  - On `mem_ready`, `freeze`, `!branch_taken`:
    - Next: `buf` <= `mem_rdata`; go to HOLD.
    - Outputs in this cycle: `valid`=1 with the same data, which is ignored because IF/ID is frozen.
  - If `mem_ready`=0: `valid`=0 and `Instruction`=`NOP_INSTR`.
- **HOLD**:
  - `mem_req`=0.
  - Outputs: `valid`=1, `Instruction`=`buf`, `PC`=`pc_reg`+4.
  - When `freeze`=0: `pc_reg` <= `pc_reg`+4; go to REQ.
- **DRAIN**:
  - Keeps `mem_req`=1 at the old `pc_reg` until `mem_ready`. The returned data is discarded.
  - Outputs: `valid`=0, `Instruction`=`NOP_INSTR`.
  - On `mem_ready`: `pc_reg` <= `target`; go to REQ.
- **Branch priority**: `branch_taken` overrides `freeze` in every state.
  - REQ with `mem_ready`: data dropped; `pc_reg` <= `branch_address`; stay in REQ.
  - REQ without `mem_ready`: `target` <= `branch_address`; go to DRAIN.
  - HOLD: `buf` discarded; `pc_reg` <= `branch_address`; go to REQ.
  - DRAIN: `target` <= `branch_address`, newest wins. If `mem_ready` is also high, `pc_reg` <= `branch_address`.
  - In every branch cycle: `valid`=0 and `Instruction`=`NOP_INSTR`.
- **Arithmetic**: PC increments by 4, modulo 2^`ADDRESS_LEN`; 32'hFFFFFFFC wraps to 0. `branch_address[1:0]` is ignored and forced to 0.

## Timing
- Zero-wait memory: one instruction per cycle. The instruction requested in cycle N is presented in cycle N, registered by IF/ID at the end of N, and the next address is issued in N+1.
- k wait states cost k bubble cycles.
- Branch in cycle N with the request completing: the first target instruction can be valid in N+1.
- Branch while a request is outstanding: the target request starts the cycle after the old request's `mem_ready`.
- Freeze release from HOLD: the next request is issued one cycle after `freeze` falls.
- Outputs depend combinationally on `mem_rdata`, `mem_ready`, `freeze` and `branch_taken`. No output-to-input combinational path exists on the memory side.

## Configuration
- `IF_HOLD_BUFFER_EN` defined: HOLD state and `buf` exist, as described above.
- `IF_HOLD_BUFFER_EN` undefined:
  - No buffer. `mem_ready` with `freeze` drops the data; `pc_reg` is unchanged and the fetch stays in REQ.
  - The same address is re-requested every cycle until a `mem_ready` arrives with `freeze`=0.
  - `valid` still follows the REQ rules.

## Test plan
- Reset, then zero-wait memory returning `addr`+32'h100: consecutive cycles present `PC`=4, 8, 12 with `Instruction`=32'h100, 32'h104, 32'h108 and `valid`=1.
- Memory with 2 wait states: one valid instruction every 3 cycles; bubbles show `Instruction`=32'hE1A00000 and `valid`=0; `mem_addr` stays stable throughout each request.
- `freeze` high for 3 cycles across a `mem_ready` at address 0x10:
  - With `IF_HOLD_BUFFER_EN`: one request; HOLD presents 0x10's word; 0x14 is requested the cycle after release.
  - Without the macro: 0x10 is re-requested until a `mem_ready` arrives with `freeze`=0.
- `branch_taken` to 0x200 while a request to 0x40 is stalled: the 0x40 data is discarded, then `mem_addr`=0x200; the next valid instruction has `PC`=0x204. `valid`=0 throughout DRAIN.
- `branch_taken` with `freeze`=1 in the same cycle: the redirect wins; `pc_reg`=`branch_address`.
- `rst` asserted while a request is outstanding, and the PC wrap case:
  - During reset: `mem_req`=0, `valid`=0.
  - After reset: the fetch restarts at `RESET_PC`.
  - Branch to 0xFFFFFFFC: the following fetch address is 0x0.
